// File: rtl/div_tick_gen_pkg.sv
// Shared definitions for the clock-enable divider: FSM encoding, ratio width and ratio floor.
package div_tick_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int                   DIV_N_W   = 5;
    localparam logic [DIV_N_W-1:0]   DIV_N_MIN = DIV_N_W'(2);

    // Ratios below 2 cannot produce a distinct tick period, so they run as 2.
    function automatic logic [DIV_N_W-1:0] clamp_n(input logic [DIV_N_W-1:0] n);
        return (n < DIV_N_MIN) ? DIV_N_MIN : n;
    endfunction

endpackage

// File: rtl/div_tick_gen_core.sv
// Divider core: latched ratio, modulo-N phase counter, terminal compare and registered tick.
module div_tick_core
    import div_tick_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_run,
    input  logic [DIV_N_W-1:0] i_div_n,
    output logic [DIV_N_W-1:0] o_div_cnt,
    output logic [DIV_N_W-1:0] o_n_reg,
    output logic               o_tick
);

    logic [DIV_N_W-1:0] r_div_cnt;
    logic [DIV_N_W-1:0] r_n;
    logic               r_tick;
    logic               w_term;

    assign w_term = (r_div_cnt == (r_n - DIV_N_W'(1)));

    // i_run is low on the edge that leaves RUN, so that edge neither ticks nor counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_n       <= DIV_N_MIN;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_load) begin
                r_n       <= clamp_n(i_div_n);
                r_div_cnt <= '0;
            end else if (i_run) begin
                r_tick    <= w_term;
                r_div_cnt <= w_term ? '0 : r_div_cnt + DIV_N_W'(1);
            end else begin
                r_div_cnt <= '0;
            end
        end
    end

    assign o_div_cnt = r_div_cnt;
    assign o_n_reg   = r_n;
    assign o_tick    = r_tick;

endmodule

// File: rtl/div_tick_gen.sv
// Start/stop controlled clock-enable generator: one tick per N clocks, a divided level and a tick tally.
module div_tick_gen
    import div_tick_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_N_W-1:0] div_n,
    output logic               busy,
    output logic               tick,
    output logic               div_lvl,
    output logic [CNT_W-1:0]   tick_cnt,
    output logic               cnt_wrap
);

    state_t             r_state;
    logic               r_busy;
    logic               r_div_lvl;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic               r_cnt_wrap;

    logic               w_accept;
    logic               w_run_stay;
    logic [DIV_N_W-1:0] w_div_cnt;
    logic [DIV_N_W-1:0] w_n_reg;
    logic               w_tick;

    // stop dominates start in both states
    assign w_accept   = (r_state == ST_IDLE) && start && !stop;
    assign w_run_stay = (r_state == ST_RUN) && !stop;

    div_tick_core u_core (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_run     (w_run_stay),
        .i_div_n   (div_n),
        .o_div_cnt (w_div_cnt),
        .o_n_reg   (w_n_reg),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_div_lvl  <= 1'b0;
            r_tick_cnt <= '0;
            r_cnt_wrap <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
                ST_RUN: if (stop) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            r_div_lvl  <= w_run_stay && (w_div_cnt < (w_n_reg >> 1));
            r_cnt_wrap <= w_tick && (r_tick_cnt == '1);

            if (w_accept)
                r_tick_cnt <= '0;
            else if (w_tick)
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    assign busy     = r_busy;
    assign tick     = w_tick;
    assign div_lvl  = r_div_lvl;
    assign tick_cnt = r_tick_cnt;
    assign cnt_wrap = r_cnt_wrap;

endmodule

// File: tb/tb_div_tick_gen.sv
// Directed bench for div_tick_gen: inputs change and outputs are sampled on the falling edge.
module tb_div_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [4:0] div_n;
    logic       busy;
    logic       tick;
    logic       div_lvl;
    logic [7:0] tick_cnt;
    logic       cnt_wrap;

    int checks = 0;
    int errors = 0;

    div_tick_gen #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .div_n    (div_n),
        .busy     (busy),
        .tick     (tick),
        .div_lvl  (div_lvl),
        .tick_cnt (tick_cnt),
        .cnt_wrap (cnt_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit k of each vector holds tick / div_lvl seen after the (k+1)-th rising edge.
    task automatic collect(input int n, output logic [31:0] tv, output logic [31:0] lv);
        tv = '0;
        lv = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tv[k] = tick;
            lv[k] = div_lvl;
        end
    endtask

    initial begin
        logic [31:0] tv, lv;
        int wraps, wrap_k, wrap_val, pre_val;

        rst = 1'b0; start = 1'b0; stop = 1'b0; div_n = 5'd0;
        step(2);
        chk("reset_outputs", {27'd0, busy, tick, div_lvl, cnt_wrap, 1'b0}, 32'd0);
        chk("reset_tick_cnt", tick_cnt, 32'd0);
        rst = 1'b1;
        step(1);
        chk("idle_after_reset", busy, 32'd0);

        // N=4; start held high through RUN and div_n altered mid-run, both ignored
        div_n = 5'd4; start = 1'b1;
        step(1);
        div_n = 5'd7;
        chk("n4_busy", busy, 32'd1);
        chk("n4_tick_first_cycle", {30'd0, tick, div_lvl}, 32'd0);
        collect(12, tv, lv);
        chk("n4_tick_pattern", tv, 32'h888);
        chk("n4_lvl_pattern", lv, 32'h333);
        step(1);
        chk("n4_tick_cnt_3", tick_cnt, 32'd3);
        stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("n4_stop_idle", {29'd0, busy, tick, div_lvl}, 32'd0);
        chk("n4_tick_cnt_held", tick_cnt, 32'd3);
        step(3);
        chk("idle_hold_busy", busy, 32'd0);
        chk("idle_hold_tick_cnt", tick_cnt, 32'd3);

        // restart picks up div_n=7 and clears tick_cnt
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("n7_tick_cnt_clear", tick_cnt, 32'd0);
        chk("n7_busy", busy, 32'd1);
        collect(14, tv, lv);
        chk("n7_tick_pattern", tv, 32'h2040);
        step(6);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_on_terminal_no_tick", {30'd0, busy, tick}, 32'd0);
        chk("stop_on_terminal_tick_cnt", tick_cnt, 32'd2);

        // div_n=0 and 1 clamp to 2
        div_n = 5'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        collect(6, tv, lv);
        chk("n0_tick_pattern", tv, 32'h2A);
        chk("n0_lvl_pattern", lv, 32'h15);
        stop = 1'b1; step(1); stop = 1'b0;

        div_n = 5'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        collect(6, tv, lv);
        chk("n1_tick_pattern", tv, 32'h2A);
        stop = 1'b1; step(1); stop = 1'b0;

        div_n = 5'd5; start = 1'b1;
        step(1);
        start = 1'b0;
        collect(10, tv, lv);
        chk("n5_tick_pattern", tv, 32'h210);
        chk("n5_lvl_pattern", lv, 32'h063);
        stop = 1'b1; step(1); stop = 1'b0;

        // start and stop together in IDLE: no start
        start = 1'b1; stop = 1'b1;
        step(1);
        chk("start_stop_idle_a", busy, 32'd0);
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle_b", busy, 32'd0);
        chk("start_stop_idle_tick_cnt", tick_cnt, 32'd2);

        // N=2 for 600 edges: tick_cnt wraps exactly once, after edge 513
        div_n = 5'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        wraps = 0; wrap_k = 0; wrap_val = -1; pre_val = -1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 512) pre_val = int'(tick_cnt);
            if (cnt_wrap) begin
                wraps++;
                if (wraps == 1) begin
                    wrap_k   = k;
                    wrap_val = int'(tick_cnt);
                end
            end
        end
        chk("wrap_pre_value", pre_val, 32'd255);
        chk("wrap_cycle", wrap_k, 32'd513);
        chk("wrap_value", wrap_val, 32'd0);
        chk("wrap_count", wraps, 32'd1);

        // reset mid-RUN, with start asserted, clears everything
        rst = 1'b0; start = 1'b1;
        step(1);
        chk("midrun_reset_outputs", {28'd0, busy, tick, div_lvl, cnt_wrap}, 32'd0);
        chk("midrun_reset_tick_cnt", tick_cnt, 32'd0);
        rst = 1'b1; start = 1'b0;
        step(3);
        chk("post_reset_idle", {30'd0, busy, tick}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_tick_gen.md
DIV_TICK_GEN -- requirements
Module: div_tick_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of the tick accumulator tick_cnt.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 start  input  1  level sampled each edge; a 1 in IDLE begins division.
REQ-005 stop  input  1  level sampled each edge; a 1 in RUN ends division.
REQ-006 div_n  input  5  division ratio N; sampled only on the accepting start edge.
REQ-007 busy  output  1  1 while in RUN.
REQ-008 tick  output  1  one-cycle pulse, one per N clocks; the enable a downstream counter consumes.
REQ-009 div_lvl  output  1  divided level; high floor(N/2) cycles per period.
REQ-010 tick_cnt  output  CNT_W  number of ticks issued since the last accepted start.
REQ-011 cnt_wrap  output  1  one-cycle pulse when tick_cnt wraps from all-ones to 0.

Function
REQ-012 FSM SHALL have two states, IDLE and RUN; IDLE -> RUN on start=1 and stop=0; RUN -> IDLE on stop=1; otherwise hold.
REQ-013 On the accepting start edge: n_reg <= div_n, clamped to 2 when div_n < 2; div_cnt <= 0; tick_cnt <= 0.
REQ-014 In RUN, div_cnt SHALL count 0 .. n_reg-1 and then wrap to 0.
REQ-015 tick SHALL be registered: tick <= 1 on an edge where state=RUN and div_cnt = n_reg-1, else 0; the first tick is high in the cycle after the N-th edge following the start edge.
REQ-016 Consecutive ticks SHALL be exactly N cycles apart while in RUN.
REQ-017 div_lvl SHALL be registered: div_lvl <= 1 when state=RUN and div_cnt < floor(n_reg/2), else 0.
REQ-018 tick_cnt SHALL increment by 1 on every edge where tick=1 and wrap modulo 2^CNT_W.
REQ-019 cnt_wrap <= 1 on the edge where tick=1 and tick_cnt is all-ones, else 0.
REQ-020 div_n changes during RUN SHALL be ignored until the next accepted start.
REQ-021 start while in RUN SHALL be ignored; it SHALL not restart or clear anything.
REQ-022 start=1 and stop=1 on the same edge: stop wins; in IDLE the FSM stays IDLE, in RUN it goes to IDLE.
REQ-023 On the RUN -> IDLE edge, div_cnt SHALL go to 0.
REQ-024 tick and div_lvl SHALL be 0 from the first cycle in IDLE; an edge that leaves RUN SHALL not issue a tick.
REQ-025 tick_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-026 rst=0 at an edge SHALL force: IDLE, div_cnt=0, n_reg=2, tick=0, div_lvl=0, tick_cnt=0, cnt_wrap=0, busy=0.
REQ-027 Reset asserted mid-RUN SHALL take effect at that edge with no tick issued; rst has priority over start and stop.

Structure
REQ-028 Shared package holds the state encoding (IDLE, RUN), DIV_N_MIN=2 and DIV_N_W=5.
REQ-029 Counter, terminal compare and tick register SHALL live in one sub-module, div_tick_core.
REQ-030 FSM, div_lvl and tick_cnt SHALL stay in the top module.

Verification
REQ-031 start with div_n=4 -> tick period 4; first tick after 4 edges; div_lvl high 2 of every 4 cycles; tick_cnt=3 after 3 ticks.
REQ-032 div_n=0 and div_n=1 -> both run as N=2, tick on every 2nd cycle; div_n=5 -> div_lvl high 2 of 5 cycles.
REQ-033 CNT_W=8, N=2, run 256 ticks -> tick_cnt returns to 0 with cnt_wrap=1 on exactly that cycle.
REQ-034 div_n changed 4 -> 7 mid-RUN -> period stays 4; stop then start -> period becomes 7 and tick_cnt clears.
REQ-035 start+stop together in IDLE -> stays IDLE; stop on the terminal-count edge -> no tick; tick_cnt held.
REQ-036 rst=0 mid-RUN -> all outputs 0 at the next edge; after release, stays IDLE until start.
